mm_vector_sched: RTL

Issue/collect controller for the 16-lane floating-point dot-product unit in the mm datapath. On `start` it walks an M-row by K-chunk matrix tile held in the matrix buffer, and issues one 16-element chunk per cycle together with the matching vector chunk. It tags each issue and writes every returned partial sum to the result buffer with row address and first/last-chunk flags, so the downstream accumulator can reduce chunks. The dot-product unit has no backpressure, so this block guarantees every in-flight result has a tag slot.

---
 rtl/mm_pkg.sv | 22 ++
 rtl/mm_vec_tag_fifo.sv | 50 +++++
 rtl/mm_vector_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types for the mm vector issue/collect scheduler.
package mm_pkg;

  // Row field width carried in each tag; matches the scheduler's CW.
  localparam int MM_CW = 8;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } mm_sched_state_t;

  // One tag per issued chunk, consumed when its partial sum returns.
  typedef struct packed {
    logic [MM_CW-1:0] row;
    logic             first;
    logic             last;
  } mm_tag_t;

endpackage

// File: rtl/mm_vec_tag_fifo.sv
// Synchronous tag FIFO. A push while full is accepted only together with
// a pop, so occupancy stays unchanged in that case.
module mm_vec_tag_fifo
  import mm_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  mm_tag_t push_data,
  input  logic    pop,
  output mm_tag_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  mm_tag_t        mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mm_vector_sched.sv
// Issue/collect controller for the 16-lane dot-product unit: walks an
// M-row by K-chunk tile, tags each issue, and writes returned partial sums
// to the result buffer with row address and first/last-chunk flags.
module mm_vector_sched
  import mm_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 10,
  parameter int CW        = MM_CW,
  parameter int KW        = 4,
  parameter int TAG_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_rows,
  input  logic [KW-1:0] cfg_chunks,
  input  logic [AW-1:0] cfg_mat_base,
  input  logic [AW-1:0] cfg_vec_base,
  input  logic [AW-1:0] cfg_res_base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mat_rd_en,
  output logic [AW-1:0] mat_rd_addr,
  output logic          vec_rd_en,
  output logic [AW-1:0] vec_rd_addr,
  output logic          vu_in_valid,
  input  logic          vu_out_valid,
  input  logic [DW-1:0] vu_out_data,
  output logic          res_wr_en,
  output logic [AW-1:0] res_wr_addr,
  output logic [DW-1:0] res_wr_data,
  output logic          res_first,
  output logic          res_last
);

  localparam int FW = $clog2(TAG_DEPTH);

  mm_sched_state_t state;
  logic [FW-1:0]   flush_cnt;
  logic [CW-1:0]   rows_q, row_q;
  logic [KW-1:0]   chunks_q, chunk_q;
  logic [AW-1:0]   mat_ptr, vec_base_q, res_base_q;

  logic            launch, degenerate, collect, pop_req, pop_ok, can_push, issue;
  logic            last_chunk, last_issue;
  logic            tag_full, tag_empty;
  mm_tag_t         push_tag, pop_tag;
  logic [CW-1:0]   cur_row, cur_rows;
  logic [KW-1:0]   cur_chunk, cur_chunks;
  logic [AW-1:0]   cur_mat, cur_vec_base;

  assign launch     = (state == ST_IDLE) && start;
  assign degenerate = (cfg_rows == '0) || (cfg_chunks == '0);
  assign collect    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign pop_req    = collect && vu_out_valid;
  assign pop_ok     = pop_req && !tag_empty;
  assign can_push   = !tag_full || pop_ok;
  assign issue      = (launch && !degenerate) || ((state == ST_ISSUE) && can_push);

  // The first issue happens on the launch edge, so it walks from the cfg
  // inputs directly; later issues walk from the latched copies.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    cur_row      = row_q;
    cur_chunk    = chunk_q;
    cur_rows     = rows_q;
    cur_chunks   = chunks_q;
    cur_mat      = mat_ptr;
    cur_vec_base = vec_base_q;
    if (launch) begin
      cur_row      = '0;
      cur_chunk    = '0;
      cur_rows     = cfg_rows;
      cur_chunks   = cfg_chunks;
      cur_mat      = cfg_mat_base;
      cur_vec_base = cfg_vec_base;
    end
  end

  assign last_chunk = (cur_chunk == cur_chunks - KW'(1));
  assign last_issue = last_chunk && (cur_row == cur_rows - CW'(1));
  assign push_tag   = '{row: cur_row, first: (cur_chunk == '0), last: last_chunk};

  mm_vec_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (push_tag),
    .pop       (pop_req),
    .pop_data  (pop_tag),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Scheduler FSM with registered read, write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FLUSH;
      flush_cnt   <= FW'(TAG_DEPTH - 1);
      rows_q      <= '0;
      row_q       <= '0;
      chunks_q    <= '0;
      chunk_q     <= '0;
      mat_ptr     <= '0;
      vec_base_q  <= '0;
      res_base_q  <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      mat_rd_en   <= 1'b0;
      mat_rd_addr <= '0;
      vec_rd_en   <= 1'b0;
      vec_rd_addr <= '0;
      vu_in_valid <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      res_first   <= 1'b0;
      res_last    <= 1'b0;
    end else begin
      mat_rd_en   <= issue;
      vec_rd_en   <= issue;
      vu_in_valid <= mat_rd_en;
      res_wr_en   <= pop_ok;
      done        <= 1'b0;

      if (issue) begin
        mat_rd_addr <= cur_mat;
        vec_rd_addr <= cur_vec_base + AW'(cur_chunk);
        mat_ptr     <= cur_mat + AW'(1);
        row_q       <= last_chunk ? cur_row + CW'(1) : cur_row;
        chunk_q     <= last_chunk ? '0 : cur_chunk + KW'(1);
      end

      if (pop_ok) begin
        res_wr_addr <= res_base_q + AW'(pop_tag.row);
        res_wr_data <= vu_out_data;
        res_first   <= pop_tag.first;
        res_last    <= pop_tag.last;
      end

      // A result with no outstanding tag cannot be attributed to a row.
      if (pop_req && tag_empty) err <= 1'b1;

      case (state)
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        ST_IDLE: begin
          if (start) begin
            rows_q     <= cfg_rows;
            chunks_q   <= cfg_chunks;
            vec_base_q <= cfg_vec_base;
            res_base_q <= cfg_res_base;
            err        <= 1'b0;
            busy       <= 1'b1;
            if (degenerate) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (last_issue) begin
              state <= ST_DRAIN;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue && last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // All tags were pushed before DRAIN, so an empty FIFO with a write
          // in flight means the final result is being written now.
          if (tag_empty && res_wr_en) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

endmodule
